// File: rtl/sram_cache.sv
// Direct-mapped one-word-line cache between a pipeline MEM stage and an SRAM controller.
// Read hits answer combinationally; read misses fill and writes go through, with freeze held until sram_ready.
module sram_cache #(
  parameter int NUM_LINES = 128,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      address,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [31:0]      writeData,
  output logic [31:0]      readData,
  output logic             freeze,
  output logic             sram_rd_en,
  output logic             sram_wr_en,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_writeData,
  input  logic [31:0]      sram_readData,
  input  logic             sram_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             is_rd, is_wr, hit;
  logic             fill_en, upd_en;
  logic             unused_addr_bits;

  assign idx              = address[IDX_W+1:2];
  assign tag              = address[31:IDX_W+2];
  assign unused_addr_bits = ^address[1:0];

  // A simultaneous rd_en/wr_en is handled as a store.
  assign is_wr = wr_en;
  assign is_rd = rd_en & ~wr_en;
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);

  assign sram_address   = address;
  assign sram_writeData = writeData;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_wr)             state_d = WR_THRU;
        else if (is_rd && !hit) state_d = RD_MISS;
      end
      RD_MISS: if (sram_ready) state_d = IDLE;
      WR_THRU: if (sram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst so the reset-state values hold even with a request present.
  always_comb begin
    readData   = '0;
    freeze     = 1'b0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (is_rd && hit) readData = data_q[idx];
          if (is_wr || (is_rd && !hit)) freeze = 1'b1;
        end
        RD_MISS: begin
          sram_rd_en = 1'b1;
          if (sram_ready) readData = sram_readData;
          else            freeze   = 1'b1;
        end
        WR_THRU: begin
          sram_wr_en = 1'b1;
          freeze     = ~sram_ready;
        end
        default: ;
      endcase
    end
  end

  assign fill_en = (state_q == RD_MISS) && sram_ready;
  assign upd_en  = (state_q == WR_THRU) && sram_ready && hit;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == IDLE && is_rd) begin
      if (hit && hit_cnt_q != {CNT_W{1'b1}})    hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      if (!hit && miss_cnt_q != {CNT_W{1'b1}})  miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (fill_en) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= sram_readData;
    end else if (upd_en) begin
      data_q[idx] <= writeData;
    end
  end

endmodule

// File: tb/tb_sram_cache.sv
// Directed bench for sram_cache: the bench plays the SRAM controller and scoreboards load data.
module tb_sram_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        freeze;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_address;
  logic [31:0] sram_writeData;
  logic [31:0] sram_readData = '0;
  logic        sram_ready = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  sram_cache dut (
    .clk(clk), .rst(rst), .address(address), .rd_en(rd_en), .wr_en(wr_en),
    .writeData(writeData), .readData(readData), .freeze(freeze),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_writeData(sram_writeData), .sram_readData(sram_readData),
    .sram_ready(sram_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request from a negedge; sram_ready is pulsed ready_at cycles after the request.
  task automatic access(input string tag, input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input int ready_at, input logic [31:0] rdat,
                        input int exp_frz, input logic chk_data, input logic [31:0] exp_data);
    int   c;
    logic done;
    address = a; rd_en = rd; wr_en = wr; writeData = wd; sram_readData = rdat;
    if (chk_data) exp_q.push_back(exp_data);
    c = 0; done = 1'b0;
    while (c < 32 && !done) begin
      sram_ready = (c == ready_at);
      #1;
      if (!freeze) begin
        done = 1'b1;
        chk({tag, "_frz_cycles"}, c, exp_frz);
        chk({tag, "_sram_addr"}, sram_address, a);
        chk({tag, "_sram_wdata"}, sram_writeData, wd);
        if (chk_data) chk({tag, "_rdata"}, readData, exp_q.pop_front());
      end else begin
        chk({tag, "_sram_rd"}, {31'b0, sram_rd_en}, {31'b0, (c > 0) && rd && !wr});
        chk({tag, "_sram_wr"}, {31'b0, sram_wr_en}, {31'b0, (c > 0) && wr});
        @(negedge clk);
        c++;
      end
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=%0d", tag, c, exp_frz);
    end
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0; sram_ready = 1'b0;
  endtask

  initial begin
    // Reset forcing, with a request present.
    address = 32'h400; rd_en = 1'b1;
    #1;
    chk("rst_freeze", {31'b0, freeze}, 32'h0);
    chk("rst_rdata", readData, 32'h0);
    chk("rst_sram_rd", {31'b0, sram_rd_en}, 32'h0);
    chk("rst_sram_wr", {31'b0, sram_wr_en}, 32'h0);
    chk("rst_hits", {16'b0, hit_count}, 32'h0);
    chk("rst_misses", {16'b0, miss_count}, 32'h0);
    repeat (2) @(negedge clk);
    rd_en = 1'b0; rst = 1'b1;
    @(negedge clk);

    access("cold_rd", 32'h400, 1, 0, 32'h0, 3, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF);
    chk("cold_misses", {16'b0, miss_count}, 32'd1);
    chk("cold_hits", {16'b0, hit_count}, 32'd0);

    access("reread", 32'h400, 1, 0, 32'h0, -1, 32'h0, 0, 1, 32'hDEADBEEF);
    chk("reread_hits", {16'b0, hit_count}, 32'd1);

    access("st_hit", 32'h400, 0, 1, 32'h12345678, 2, 32'h0, 2, 0, 32'h0);
    access("ld_after_st", 32'h400, 1, 0, 32'h0, -1, 32'h0, 0, 1, 32'h12345678);
    chk("ld_after_st_hits", {16'b0, hit_count}, 32'd2);

    access("conflict_600", 32'h600, 1, 0, 32'h0, 1, 32'hCAFE0600, 1, 1, 32'hCAFE0600);
    chk("conflict_misses", {16'b0, miss_count}, 32'd2);
    access("hit_600", 32'h600, 1, 0, 32'h0, -1, 32'h0, 0, 1, 32'hCAFE0600);
    access("evicted_400", 32'h400, 1, 0, 32'h0, 2, 32'h11110400, 2, 1, 32'h11110400);
    chk("evicted_misses", {16'b0, miss_count}, 32'd3);

    access("st_miss_800", 32'h800, 0, 1, 32'hBAD00800, 1, 32'h0, 1, 0, 32'h0);
    access("after_st_miss", 32'h400, 1, 0, 32'h0, -1, 32'h0, 0, 1, 32'h11110400);
    chk("after_st_miss_hits", {16'b0, hit_count}, 32'd4);

    access("rd_wr_both", 32'h404, 1, 1, 32'h55AA55AA, 2, 32'h0, 2, 0, 32'h0);
    access("ld_404", 32'h404, 1, 0, 32'h0, 1, 32'h04040404, 1, 1, 32'h04040404);
    chk("ld_404_misses", {16'b0, miss_count}, 32'd4);

    // Stray ready with no request present.
    sram_ready = 1'b1; sram_readData = 32'hFFFFFFFF;
    #1;
    chk("idle_rdy_freeze", {31'b0, freeze}, 32'h0);
    chk("idle_rdy_rdata", readData, 32'h0);
    chk("idle_rdy_sram", {30'b0, sram_rd_en, sram_wr_en}, 32'h0);
    @(negedge clk);
    sram_ready = 1'b0;
    access("idle_rdy_hit", 32'h400, 1, 0, 32'h0, -1, 32'h0, 0, 1, 32'h11110400);

    // Reset asserted while a fill is outstanding.
    address = 32'h408; rd_en = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_miss_sram_rd", {31'b0, sram_rd_en}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_sram_rd", {31'b0, sram_rd_en}, 32'h0);
    chk("abort_freeze", {31'b0, freeze}, 32'h0);
    chk("abort_hits", {16'b0, hit_count}, 32'h0);
    chk("abort_misses", {16'b0, miss_count}, 32'h0);
    @(negedge clk);
    rd_en = 1'b0; rst = 1'b1;
    access("after_abort_408", 32'h408, 1, 0, 32'h0, 2, 32'h00000408, 2, 1, 32'h00000408);
    access("after_abort_400", 32'h400, 1, 0, 32'h0, 1, 32'h00000777, 1, 1, 32'h00000777);

    // Hit-counter saturation: continuous hits on 0x400.
    address = 32'h400; rd_en = 1'b1;
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_fffe", {16'b0, hit_count}, 32'h0000FFFE);
    chk("sat_rdata", readData, 32'h00000777);
    @(negedge clk);
    #1;
    chk("sat_ffff", {16'b0, hit_count}, 32'h0000FFFF);
    repeat (5) @(negedge clk);
    #1;
    chk("sat_hold", {16'b0, hit_count}, 32'h0000FFFF);
    rd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
